// File: rtl/hd_pkg.sv
// Shared types and constants for the Hamming(7,4) chained accumulator.
//   state_t     : controller states
//   SYN_*       : syndrome {s1,s2,s3} value that points at each codeword bit
//   rule_t      : combine-rule select, keyed by {e_prev, e}
package hd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUT     = 2'd2
  } state_t;

  localparam logic [2:0] SYN_NONE = 3'b000;
  localparam logic [2:0] SYN_B0   = 3'b011;
  localparam logic [2:0] SYN_B1   = 3'b101;
  localparam logic [2:0] SYN_B2   = 3'b110;
  localparam logic [2:0] SYN_B3   = 3'b111;
  localparam logic [2:0] SYN_B4   = 3'b001;
  localparam logic [2:0] SYN_B5   = 3'b010;
  localparam logic [2:0] SYN_B6   = 3'b100;

  typedef enum logic [1:0] {
    RULE_2A_ADD_B = 2'b00,
    RULE_2A_SUB_B = 2'b01,
    RULE_A_SUB_2B = 2'b10,
    RULE_A_ADD_2B = 2'b11
  } rule_t;

endpackage

// File: rtl/hd74_decode.sv
// Combinational Hamming(7,4) single-error decoder.
//   in_cw  : received codeword {p6,p5,p4,d3,d2,d1,d0}
//   c      : corrected data nibble, two's-complement signed
//   e      : received (pre-correction) value of the bit the syndrome points at,
//            0 when the syndrome is zero
//   syn_nz : syndrome is nonzero
module hd74_decode
  import hd_pkg::*;
(
  input  logic [6:0] in_cw,
  output logic [3:0] c,
  output logic       e,
  output logic       syn_nz
);

  logic [2:0] syn;

  assign syn = {in_cw[6] ^ in_cw[3] ^ in_cw[2] ^ in_cw[1],
                in_cw[5] ^ in_cw[3] ^ in_cw[2] ^ in_cw[0],
                in_cw[4] ^ in_cw[3] ^ in_cw[1] ^ in_cw[0]};

  assign syn_nz = |syn;

  // Parity-bit errors still report e but leave the data nibble untouched.
  always_comb begin
    c = in_cw[3:0];
    e = 1'b0;
    case (syn)
      SYN_B0: begin c[0] = ~in_cw[0]; e = in_cw[0]; end
      SYN_B1: begin c[1] = ~in_cw[1]; e = in_cw[1]; end
      SYN_B2: begin c[2] = ~in_cw[2]; e = in_cw[2]; end
      SYN_B3: begin c[3] = ~in_cw[3]; e = in_cw[3]; end
      SYN_B4: e = in_cw[4];
      SYN_B5: e = in_cw[5];
      SYN_B6: e = in_cw[6];
      default: ;
    endcase
  end

endmodule

// File: rtl/hd_chain_acc.sv
// Streaming Hamming(7,4) decode / chained accumulate.
// Collects NUM_CW codewords per transaction, corrects each one and folds its
// signed data nibble into an OUT_W-bit wrapping accumulator using a rule
// selected by the error bits of the previous and current codeword.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : codeword handshake (in_ready low while a result waits)
//   in_cw                 : codeword {p6,p5,p4,d3,d2,d1,d0}
//   out_valid/out_ready   : result handshake
//   out_n                 : signed accumulated result
//   out_err_cnt           : codewords with nonzero syndrome in the transaction
//   out_ovf               : some accumulation step wrapped in the transaction
module hd_chain_acc
  import hd_pkg::*;
#(
  parameter int NUM_CW = 2,
  parameter int OUT_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_cw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_n,
  output logic [4:0]       out_err_cnt,
  output logic             out_ovf
);

  localparam int         FW       = OUT_W + 3;
  localparam logic [4:0] LAST_IDX = 5'(NUM_CW);

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic [4:0]       idx;
  logic             e_prev;
  logic [4:0]       err_cnt;
  logic             ovf;

  logic [3:0]          c;
  logic                e;
  logic                syn_nz;
  logic signed [FW-1:0] a_x;
  logic signed [FW-1:0] b_x;
  logic signed [FW-1:0] full;
  logic [OUT_W-1:0]    step;
  logic                wrap;
  rule_t               rule;
  logic [4:0]          err_cnt_nxt;
  logic [4:0]          idx_nxt;
  logic                ovf_nxt;

  hd74_decode u_dec (
    .in_cw  (in_cw),
    .c      (c),
    .e      (e),
    .syn_nz (syn_nz)
  );

  assign in_ready = (state != OUT);

  always_comb begin
    a_x  = {{3{acc[OUT_W-1]}}, acc};
    b_x  = {{(FW-4){c[3]}}, c};
    rule = rule_t'({e_prev, e});
    full = '0;
    case (rule)
      RULE_2A_ADD_B: full = a_x + a_x + b_x;
      RULE_2A_SUB_B: full = a_x + a_x - b_x;
      RULE_A_SUB_2B: full = a_x - b_x - b_x;
      RULE_A_ADD_2B: full = a_x + b_x + b_x;
      default:       full = '0;
    endcase
    step        = full[OUT_W-1:0];
    // Wrap is detected by re-extending the truncated value and comparing.
    wrap        = ({{3{step[OUT_W-1]}}, step} != full);
    err_cnt_nxt = err_cnt + {4'b0, syn_nz};
    idx_nxt     = idx + 5'd1;
    ovf_nxt     = ovf | wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      idx         <= '0;
      e_prev      <= 1'b0;
      err_cnt     <= '0;
      ovf         <= 1'b0;
      out_valid   <= 1'b0;
      out_n       <= '0;
      out_err_cnt <= '0;
      out_ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc     <= {{(OUT_W-4){c[3]}}, c};
            e_prev  <= e;
            err_cnt <= {4'b0, syn_nz};
            ovf     <= 1'b0;
            idx     <= 5'd1;
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            acc     <= step;
            e_prev  <= e;
            err_cnt <= err_cnt_nxt;
            ovf     <= ovf_nxt;
            idx     <= idx_nxt;
            if (idx_nxt == LAST_IDX) begin
              state       <= OUT;
              out_valid   <= 1'b1;
              out_n       <= step;
              out_err_cnt <= err_cnt_nxt;
              out_ovf     <= ovf_nxt;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            idx       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_chain_acc.sv
module tb_hd_chain_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_ovf_a;
  logic [6:0] in_cw_a;
  logic [5:0] out_n_a;
  logic [4:0] out_err_a;
  logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_ovf_b;
  logic [6:0] in_cw_b;
  logic [5:0] out_n_b;
  logic [4:0] out_err_b;

  hd_chain_acc #(.NUM_CW(2), .OUT_W(6)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_cw(in_cw_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_n(out_n_a), .out_err_cnt(out_err_a), .out_ovf(out_ovf_a)
  );

  hd_chain_acc #(.NUM_CW(4), .OUT_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_cw(in_cw_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_n(out_n_b), .out_err_cnt(out_err_b), .out_ovf(out_ovf_b)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- accessors (s=0 -> dut_a, s=1 -> dut_b) ----------------
  function automatic logic get_valid(input bit s);
    return s ? out_valid_b : out_valid_a;
  endfunction
  function automatic logic get_ready(input bit s);
    return s ? in_ready_b : in_ready_a;
  endfunction
  function automatic longint get_n(input bit s);
    return s ? longint'($signed(out_n_b)) : longint'($signed(out_n_a));
  endfunction
  function automatic longint get_err(input bit s);
    return s ? longint'(out_err_b) : longint'(out_err_a);
  endfunction
  function automatic logic get_ovf(input bit s);
    return s ? out_ovf_b : out_ovf_a;
  endfunction

  task automatic set_in(input bit s, input logic v, input logic [6:0] cw);
    if (s) begin in_valid_b = v; in_cw_b = cw; end
    else   begin in_valid_a = v; in_cw_a = cw; end
  endtask
  task automatic set_ordy(input bit s, input logic v);
    if (s) out_ready_b = v; else out_ready_a = v;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] syn_of(input logic [6:0] cw);
    return {^(cw & 7'b1001110), ^(cw & 7'b0101101), ^(cw & 7'b0011011)};
  endfunction

  // The erroneous position is the bit whose own syndrome column matches.
  function automatic void dec_ref(input logic [6:0] cw, output int c, output int e,
                                  output int nz);
    logic [2:0] s;
    logic [3:0] d;
    logic [6:0] u;
    int pos;
    s = syn_of(cw);
    d = cw[3:0];
    pos = -1;
    for (int i = 0; i < 7; i++) begin
      u = 7'b1 << i;
      if (s != 3'b000 && syn_of(u) == s) pos = i;
    end
    e = 0;
    if (pos >= 0) begin
      e = int'(cw[pos]);
      if (pos < 4) d[pos] = ~d[pos];
    end
    c  = d[3] ? int'(d) - 16 : int'(d);
    nz = (s != 3'b000) ? 1 : 0;
  endfunction

  function automatic longint wrap6(input longint v);
    longint r;
    r = ((v % 64) + 64) % 64;
    if (r >= 32) r = r - 64;
    return r;
  endfunction

  function automatic void ref_txn(input logic [6:0] cws[16], input int n,
                                  output int rn, output int rerr, output int rovf);
    longint acc, full;
    int ep, c, e, nz;
    acc = 0; ep = 0; rerr = 0; rovf = 0;
    for (int i = 0; i < n; i++) begin
      dec_ref(cws[i], c, e, nz);
      rerr += nz;
      if (i == 0) acc = c;
      else begin
        if (ep == 0 && e == 0)      full = 2 * acc + c;
        else if (ep == 0)           full = 2 * acc - c;
        else if (e == 0)            full = acc - 2 * c;
        else                        full = acc + 2 * c;
        if (wrap6(full) != full) rovf = 1;
        acc = wrap6(full);
      end
      ep = e;
    end
    rn = int'(acc);
  endfunction

  // ---------------- drivers ----------------
  task automatic push(input bit s, input logic [6:0] cw);
    int waited;
    waited = 0;
    set_in(s, 1'b1, cw);
    while (!get_ready(s) && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 20) chk("push_ready_timeout", 0, 1);
    @(posedge clk); #1;
    set_in(s, 1'b0, 7'h00);
  endtask

  task automatic check_result(input bit s, input string tag, input int en,
                              input int eerr, input int eovf);
    chk({tag, "_valid"}, longint'(get_valid(s)), 1);
    chk({tag, "_n"}, get_n(s), longint'(en));
    chk({tag, "_err"}, get_err(s), longint'(eerr));
    chk({tag, "_ovf"}, longint'(get_ovf(s)), longint'(eovf));
  endtask

  task automatic release_out(input bit s, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", longint'(get_valid(s)), 1);
    end
    set_ordy(s, 1'b1);
    @(posedge clk); #1;
    set_ordy(s, 1'b0);
    chk("release_valid", longint'(get_valid(s)), 0);
  endtask

  task automatic check_reset(input bit s);
    chk("rst_valid", longint'(get_valid(s)), 0);
    chk("rst_n_out", get_n(s), 0);
    chk("rst_err", get_err(s), 0);
    chk("rst_ovf", longint'(get_ovf(s)), 0);
    chk("rst_in_ready", longint'(get_ready(s)), 1);
  endtask

  typedef struct {
    logic [6:0] cw0;
    logic [6:0] cw1;
    int         n;
    int         err;
    int         ovf;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    logic [6:0] cws[16];
    int rn, rerr, rovf, n;
    bit s;

    in_valid_a = 0; in_cw_a = '0; out_ready_a = 0;
    in_valid_b = 0; in_cw_b = '0; out_ready_b = 0;
    foreach (cws[i]) cws[i] = '0;

    tbl[0] = '{7'h63, 7'h55,  11, 0, 0};
    tbl[1] = '{7'h63, 7'h57,   1, 1, 0};
    tbl[2] = '{7'h6B, 7'h55,  -7, 1, 0};
    tbl[3] = '{7'h07, 7'h07,  21, 0, 0};
    tbl[4] = '{7'h6B, 7'h57,  13, 2, 0};

    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    rst_n = 1;
    @(posedge clk); #1;

    // Table: two-codeword transactions, back-to-back, one-cycle result latency
    foreach (tbl[i]) begin
      push(0, tbl[i].cw0);
      chk("tbl_valid_early", longint'(out_valid_a), 0);
      push(0, tbl[i].cw1);
      check_result(0, "tbl", tbl[i].n, tbl[i].err, tbl[i].ovf);
      release_out(0, i % 3);
    end

    // NUM_CW=4: 7, 21, 49 wraps to -15, then -23
    for (int i = 0; i < 4; i++) begin
      push(1, 7'h07);
      if (i < 3) chk("b4_valid_early", longint'(out_valid_b), 0);
    end
    check_result(1, "b4", -23, 0, 1);
    release_out(1, 0);

    // Backpressure: result held, inputs refused while out_ready stays low
    push(0, 7'h63);
    push(0, 7'h55);
    check_result(0, "bp", 11, 0, 0);
    set_in(0, 1'b1, 7'h6B);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", longint'(in_ready_a), 0);
      chk("bp_n_stable", get_n(0), 11);
      chk("bp_valid", longint'(out_valid_a), 1);
    end
    set_ordy(0, 1'b1);
    @(posedge clk); #1;
    set_ordy(0, 1'b0);
    chk("bp_released", longint'(out_valid_a), 0);
    chk("bp_ready_back", longint'(in_ready_a), 1);
    @(posedge clk); #1;          // 7'h6B accepted on this edge
    set_in(0, 1'b0, 7'h00);
    push(0, 7'h55);
    check_result(0, "bp_next", -7, 1, 0);
    release_out(0, 0);

    // Mid-transaction reset discards the partial transaction
    push(1, 7'h07);
    push(1, 7'h07);
    push(1, 7'h07);
    push(1, 7'h07);
    push(0, 7'h6B);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    check_reset(0);
    check_reset(1);
    push(0, 7'h63);
    push(0, 7'h55);
    check_result(0, "post_rst", 11, 0, 0);
    release_out(0, 1);

    // Randomized transactions against the model, with input gaps and stalls
    for (int t = 0; t < 40; t++) begin
      s = t[0];
      n = s ? 4 : 2;
      for (int i = 0; i < n; i++) cws[i] = 7'($urandom);
      ref_txn(cws, n, rn, rerr, rovf);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        push(s, cws[i]);
      end
      check_result(s, s ? "rnd_b" : "rnd_a", rn, rerr, rovf);
      release_out(s, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
